// File: rtl/pkg_dma_type.sv
// Shared types and constants for the video DMA scheduler.
// Beat geometry and the AXI 4 KiB rule live here so every block agrees.
`ifndef ROCKET_MEM_DAT_WIDTH
`define ROCKET_MEM_DAT_WIDTH 128
`endif

package pkg_dma_type;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        DONE
    } dma_state_t;

    localparam int BEAT_BYTES  = `ROCKET_MEM_DAT_WIDTH / 8;
    localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/video_dma_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted index.
// Reset parks the pointer on the top index so requester 0 wins first.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        grant = '0;
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(last_q) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PW'(NREQ - 1);
        end else if (accept) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/video_dma_scheduler.sv
// Descriptor-driven AXI read DMA that fills video memory.
// Bursts are split at MAX_BURST and at every 4 KiB address boundary.
module video_dma_scheduler
    import pkg_dma_type::*;
#(
    parameter int NREQ          = 2,
    parameter int DATA_WIDTH    = `ROCKET_MEM_DAT_WIDTH,
    parameter int VIDEOMEM_SIZE = 18,
    parameter int MAX_BURST     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*64-1:0]            req_src,
    input  logic [NREQ*VIDEOMEM_SIZE-1:0] req_dst,
    input  logic [NREQ*32-1:0]            req_len,
    output logic [NREQ-1:0]               done,
    output logic [63:0]                   ARADDR,
    output logic [7:0]                    ARLEN,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic                          vm_we,
    output logic [VIDEOMEM_SIZE-1:0]      vm_addr,
    output logic [DATA_WIDTH-1:0]         vm_wdata,
    output logic                          busy,
    output logic                          err
);

    localparam int BB = DATA_WIDTH / 8;

    dma_state_t               state;
    dma_state_t               nxt;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          gnt_q;
    logic                     accept;
    logic [63:0]              src_q;
    logic [VIDEOMEM_SIZE-1:0] dst_q;
    logic [31:0]              rem_q;
    logic [8:0]               cnt_q;
    logic [63:0]              sel_src;
    logic [VIDEOMEM_SIZE-1:0] sel_dst;
    logic [31:0]              sel_len;
    logic [12:0]              room;
    logic [31:0]              lim;
    logic [31:0]              beats;

    assign accept = (state == ARB) && (|grant);

    rr_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_src = req_src[i*64 +: 64];
                sel_dst = req_dst[i*VIDEOMEM_SIZE +: VIDEOMEM_SIZE];
                sel_len = req_len[i*32 +: 32];
            end
        end
    end

    // src_q is kept beat-aligned, so its low 12 bits give the page offset
    always_comb begin
        room  = 13'(BOUNDARY_4K) - {1'b0, src_q[11:0]};
        lim   = 32'(room / 13'(BB));
        beats = rem_q;
        if (beats > 32'(MAX_BURST)) begin
            beats = 32'(MAX_BURST);
        end
        if (beats > lim) begin
            beats = lim;
        end
    end

    assign ARADDR    = src_q;
    assign ARLEN     = 8'(beats - 32'd1);
    assign ARVALID   = (state == ADDR);
    assign RREADY    = (state == DATA);
    assign busy      = (state != IDLE);
    assign req_ready = accept ? grant : '0;
    assign done      = (state == DONE) ? gnt_q : '0;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (|req_valid) nxt = ARB;
            ARB: begin
                if (!(|grant)) begin
                    nxt = IDLE;
                end else if (sel_len == 32'd0) begin
                    nxt = DONE;
                end else begin
                    nxt = ADDR;
                end
            end
            ADDR: if (ARREADY) nxt = DATA;
            DATA: begin
                if (RVALID && cnt_q == 9'd1) begin
                    nxt = (rem_q == 32'd1) ? DONE : ADDR;
                end
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            vm_we    <= 1'b0;
            vm_addr  <= '0;
            vm_wdata <= '0;
            err      <= 1'b0;
        end else begin
            state <= nxt;
            vm_we <= 1'b0;
            unique case (state)
                ARB: begin
                    if (accept) begin
                        gnt_q <= grant;
                        src_q <= sel_src & ~64'(BB - 1);
                        dst_q <= sel_dst;
                        rem_q <= sel_len;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        cnt_q <= beats[8:0];
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        vm_we    <= 1'b1;
                        vm_addr  <= dst_q;
                        vm_wdata <= RDATA;
                        dst_q    <= dst_q + VIDEOMEM_SIZE'(1);
                        src_q    <= src_q + 64'(BB);
                        rem_q    <= rem_q - 32'd1;
                        cnt_q    <= cnt_q - 9'd1;
                        // our beat count rules; a bad RLAST is only flagged
                        if (RRESP != 2'd0 || RLAST != (cnt_q == 9'd1)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_dma_scheduler.sv
// Randomised bench for video_dma_scheduler with an AXI read slave.
// Expected bursts and writes come from a descriptor-level model.
module tb_video_dma_scheduler;

    localparam int NREQ = 2;
    localparam int DW   = 128;
    localparam int VMS  = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*64-1:0] req_src;
    logic [NREQ*VMS-1:0] req_dst;
    logic [NREQ*32-1:0] req_len;
    logic [NREQ-1:0]   done;
    logic [63:0]       ARADDR;
    logic [7:0]        ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              vm_we;
    logic [VMS-1:0]    vm_addr;
    logic [DW-1:0]     vm_wdata;
    logic              busy;
    logic              err;

    video_dma_scheduler #(
        .NREQ          (NREQ),
        .DATA_WIDTH    (DW),
        .VIDEOMEM_SIZE (VMS),
        .MAX_BURST     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_len   (req_len),
        .done      (done),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_wdata  (vm_wdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [63:0]  d_src [NREQ];
    logic [VMS-1:0] d_dst [NREQ];
    logic [31:0]  d_len [NREQ];
    int           m_last;

    logic [63:0]  ar_addr_q [$];
    logic [7:0]   ar_len_q [$];
    logic [VMS-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [DW-1:0] sent_q [$];
    logic [63:0]  ex_addr_q [$];
    logic [7:0]   ex_len_q [$];
    int           done_cnt [NREQ];
    int           arv_cnt;
    int           stall_seen;

    bit           ar_hs;
    bit           r_hs;
    logic [7:0]   ar_len_seen;
    bit           ar_wait;
    logic [63:0]  hold_addr;
    logic [7:0]   hold_len;
    int           stall;
    bit           inject;

    always @(negedge clk) begin
        ar_hs       = rst && ARVALID && ARREADY;
        r_hs        = rst && RVALID && RREADY;
        ar_len_seen = ARLEN;
        if (ar_hs) begin
            ar_addr_q.push_back(ARADDR);
            ar_len_q.push_back(ARLEN);
        end
        if (r_hs) sent_q.push_back(RDATA);
        if (vm_we) begin
            wr_addr_q.push_back(vm_addr);
            wr_data_q.push_back(vm_wdata);
        end
        if (ARVALID) arv_cnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (done[i]) done_cnt[i]++;
        end
        if (req_ready != '0) check_eq("ready_onehot", 128'($onehot(req_ready)), 1);
        if (rst && ARVALID && !ARREADY) begin
            stall_seen++;
            if (ar_wait) begin
                check_eq("araddr_stable", ARADDR, hold_addr);
                check_eq("arlen_stable", ARLEN, hold_len);
            end
            ar_wait   = 1'b1;
            hold_addr = ARADDR;
            hold_len  = ARLEN;
        end else begin
            ar_wait = 1'b0;
        end
    end

    // AXI read slave: random AR acceptance and random gaps between beats
    initial begin
        int bq [$];
        int left;
        int bidx;
        left = 0;
        bidx = 0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = '0;
        RRESP   = 2'd0;
        RLAST   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                bq.delete();
                left = 0;
                bidx = 0;
                ARREADY = 1'b0;
                RVALID  = 1'b0;
                RLAST   = 1'b0;
                RRESP   = 2'd0;
            end else begin
                if (ar_hs) bq.push_back(int'(ar_len_seen) + 1);
                if (r_hs) begin
                    left--;
                    bidx++;
                end
                if (left == 0 && bq.size() > 0) begin
                    left = bq.pop_front();
                    bidx = 0;
                end
                if (stall > 0) begin
                    ARREADY = 1'b0;
                    if (ARVALID) stall--;
                end else begin
                    ARREADY = ($urandom_range(0, 2) != 0);
                end
                RVALID = (left > 0) && ($urandom_range(0, 3) != 0);
                RDATA  = {$urandom, $urandom, $urandom, $urandom};
                RLAST  = (left == 1);
                RRESP  = (inject && bidx == 1) ? 2'd2 : 2'd0;
            end
        end
    end

    task automatic clear_logs();
        ar_addr_q.delete();
        ar_len_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        sent_q.delete();
        ex_addr_q.delete();
        ex_len_q.delete();
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
        arv_cnt = 0;
    endtask

    task automatic set_desc(input int i, input logic [63:0] s,
                            input logic [VMS-1:0] d, input logic [31:0] l);
        d_src[i] = s;
        d_dst[i] = d;
        d_len[i] = l;
    endtask

    task automatic drive_desc();
        for (int i = 0; i < NREQ; i++) begin
            req_src[i*64 +: 64]   = d_src[i];
            req_dst[i*VMS +: VMS] = d_dst[i];
            req_len[i*32 +: 32]   = d_len[i];
        end
    endtask

    task automatic run_desc(input logic [NREQ-1:0] mask, output int w);
        int n;
        int tot;
        int r;
        int b;
        int room;
        logic [63:0] a;
        clear_logs();
        drive_desc();
        req_valid = mask;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int k;
            k = (m_last + i) % NREQ;
            if (w < 0 && mask[k]) w = k;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        check_eq("grant", req_ready, 128'(1 << w));
        m_last = w;
        tot = n;
        @(posedge clk);
        #1;
        req_valid = '0;
        req_src   = {$urandom, $urandom, $urandom, $urandom};
        req_dst   = 36'({$urandom, $urandom});
        req_len   = {$urandom, $urandom};
        a = d_src[w] & ~64'hF;
        r = int'(d_len[w]);
        while (r > 0) begin
            room = (4096 - int'(a[11:0])) / 16;
            b = r;
            if (b > 16) b = 16;
            if (b > room) b = room;
            ex_addr_q.push_back(a);
            ex_len_q.push_back(8'(b - 1));
            a = a + 64'(b * 16);
            r = r - b;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 3000);
        check_eq("done_seen", 128'(n < 3000), 1);
        check_eq("done_who", done, 128'(1 << w));
        tot += n;
        if (d_len[w] == 0) begin
            check_eq("len0_latency", 128'(tot <= 3), 1);
            check_eq("len0_no_arvalid", arv_cnt, 0);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            check_eq("done_count", done_cnt[i], (i == w) ? 1 : 0);
        end
        check_eq("nburst", ar_addr_q.size(), ex_addr_q.size());
        for (int i = 0; i < ar_addr_q.size() && i < ex_addr_q.size(); i++) begin
            check_eq("araddr", ar_addr_q[i], ex_addr_q[i]);
            check_eq("arlen", ar_len_q[i], ex_len_q[i]);
        end
        check_eq("nwrite", wr_addr_q.size(), d_len[w]);
        for (int k = 0; k < wr_addr_q.size() && k < sent_q.size(); k++) begin
            check_eq("wr_addr", wr_addr_q[k], VMS'(d_dst[w] + VMS'(k)));
            check_eq("wr_data", wr_data_q[k], sent_q[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [63:0] s;
        logic [VMS-1:0] dd;
        req_valid = '0;
        req_src = '0;
        req_dst = '0;
        req_len = '0;
        stall = 0;
        inject = 1'b0;
        m_last = NREQ - 1;
        stall_seen = 0;
        for (int i = 0; i < NREQ; i++) set_desc(i, 64'h0, '0, 32'd0);
        clear_logs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_arvalid", ARVALID, 0);
        check_eq("rst_rready", RREADY, 0);
        check_eq("rst_vm_we", vm_we, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_vm_addr", vm_addr, 0);
        check_eq("rst_vm_wdata", vm_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        set_desc(0, 64'h0, 18'h0, 32'd0);
        set_desc(1, 64'h0, 18'h0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_desc(2'b11, w);
            check_eq("rr_order", w, i % 2);
        end

        set_desc(0, 64'h1000, 18'h10, 32'd20);
        run_desc(2'b01, w);
        check_eq("d024_addr0", ar_addr_q[0], 64'h1000);
        check_eq("d024_len0", ar_len_q[0], 15);
        check_eq("d024_addr1", ar_addr_q[1], 64'h1100);
        check_eq("d024_len1", ar_len_q[1], 3);
        check_eq("d024_last_wr", wr_addr_q[19], 18'h23);

        set_desc(0, 64'h1FC0, 18'h200, 32'd16);
        run_desc(2'b01, w);
        check_eq("d025_addr0", ar_addr_q[0], 64'h1FC0);
        check_eq("d025_len0", ar_len_q[0], 3);
        check_eq("d025_addr1", ar_addr_q[1], 64'h2000);
        check_eq("d025_len1", ar_len_q[1], 11);

        set_desc(1, 64'h5000, 18'h40, 32'd0);
        run_desc(2'b10, w);

        set_desc(0, 64'h3000, 18'h3FFFE, 32'd4);
        run_desc(2'b01, w);
        check_eq("d028_wr2", wr_addr_q[2], 18'h0);
        check_eq("d028_wr3", wr_addr_q[3], 18'h1);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                s = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) s[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
                dd = VMS'($urandom);
                if ($urandom_range(0, 3) == 0) dd = 18'h3FFF0 + VMS'($urandom_range(0, 15));
                set_desc(i, s, dd, 32'($urandom_range(0, 40)));
            end
            run_desc(2'($urandom_range(1, 3)), w);
        end
        check_eq("err_clean", err, 0);

        stall_seen = 0;
        stall = 5;
        inject = 1'b1;
        set_desc(0, 64'h4000, 18'h100, 32'd8);
        run_desc(2'b01, w);
        check_eq("ar_stall_ge5", 128'(stall_seen >= 5), 1);
        check_eq("err_set", err, 1);
        inject = 1'b0;
        set_desc(1, 64'h8000, 18'h0, 32'd3);
        run_desc(2'b10, w);
        check_eq("err_sticky", err, 1);

        clear_logs();
        set_desc(0, 64'h10000, 18'h0, 32'd64);
        drive_desc();
        req_valid = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        while (wr_addr_q.size() < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reached", 128'(wr_addr_q.size() >= 5), 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_arvalid", ARVALID, 0);
        check_eq("mid_rready", RREADY, 0);
        check_eq("mid_vm_we", vm_we, 0);
        check_eq("mid_err", err, 0);
        check_eq("mid_vm_addr", vm_addr, 0);
        check_eq("mid_vm_wdata", vm_wdata, 0);
        check_eq("mid_done", done, 0);
        m_last = NREQ - 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        repeat (30) @(negedge clk);
        check_eq("post_done0", done_cnt[0], 0);
        check_eq("post_done1", done_cnt[1], 0);
        check_eq("post_no_write", wr_addr_q.size(), 0);
        check_eq("post_busy", busy, 0);
        check_eq("post_no_arvalid", arv_cnt, 0);

        set_desc(0, 64'h2000, 18'h5, 32'd2);
        set_desc(1, 64'h3000, 18'h9, 32'd2);
        run_desc(2'b11, w);
        check_eq("ptr_after_rst", w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
